bcd2bin: RTL and testbench

- Sequential BCD-to-binary converter using reverse double dabble (shift right, subtract 3).
- Inverse of the existing binary-to-BCD converter: accepts up to 11 packed BCD digits and produces the 37-bit binary value.
- Used wherever user- or display-side decimal values must be turned back into binary counts, such as SDRAM test address and length entry.
- Same ready/start/done_tick handshake as the rest of the conversion blocks.

---
 rtl/bcd2bin_if.sv | 23 ++
 rtl/bcd2bin.sv | 136 +++++++++++++
 tb/tb_bcd2bin.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The master drives requests (start/bcd), the slave returns status and result.
interface bcd2bin_if #(
  parameter int DIGITS = 11,
  parameter int BIN_W  = 37
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ready;
  logic                  done_tick;
  logic [BIN_W-1:0]      bin;
  logic                  err;

  modport master (
    output start, bcd,
    input  ready, done_tick, bin, err
  );

  modport slave (
    input  start, bcd,
    output ready, done_tick, bin, err
  );
endinterface

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// Each OP cycle shifts {digits, binreg} right by one bit, then pulls every
// digit that reached 8 or more back down by 3. After BIN_W iterations the
// binary register holds the result and the digit register is empty.
module bcd2bin #(
  parameter int DIGITS = 11,
  parameter int BIN_W  = 37
) (
  input  logic        clk,
  input  logic        rst,
  bcd2bin_if.slave    bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIG_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   n_q, n_d;

  logic [DIG_W-1:0]   dig_sh_s;
  logic [BIN_W-1:0]   sr_sh_s;

  // True when any packed digit is outside 0..9.
  function automatic logic has_bad_digit(input logic [DIG_W-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Per-digit correction after the shift: a digit >= 8 loses 3, no carries.
  function automatic logic [DIG_W-1:0] adjust_digits(input logic [DIG_W-1:0] d);
    logic [DIG_W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i + 3]) begin
        r[4*i +: 4] = d[4*i +: 4] - 4'd3;
      end else begin
        r[4*i +: 4] = d[4*i +: 4];
      end
    end
    return r;
  endfunction

  // One-bit right shift across the digit/binary pair; a zero enters the top digit.
  always_comb begin
    dig_sh_s = {1'b0, dig_q[DIG_W-1:1]};
    sr_sh_s  = {dig_q[0], sr_q[BIN_W-1:1]};
  end

  // Next-state and datapath update for the IDLE/OP/DONE sequence.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    sr_d    = sr_q;
    n_d     = n_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dig_d = bus.bcd;
          sr_d  = {BIN_W{1'b0}};
          n_d   = CNT_W'(BIN_W);
          if (has_bad_digit(bus.bcd)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_OP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OP: begin
        dig_d = adjust_digits(dig_sh_s);
        sr_d  = sr_sh_s;
        n_d   = n_q - CNT_W'(1);
        if (n_q == CNT_W'(1)) begin
          bin_d   = sr_sh_s;
          state_d = S_DONE;
        end else begin
          state_d = S_OP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dig_q   <= {DIG_W{1'b0}};
      sr_q    <= {BIN_W{1'b0}};
      bin_q   <= {BIN_W{1'b0}};
      err_q   <= 1'b0;
      n_q     <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      sr_q    <= sr_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      n_q     <= n_d;
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.done_tick = (state_q == S_DONE);
  assign bus.bin       = bin_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: expected results are computed arithmetically
// from the digits, queued on acceptance and compared when done_tick fires.
module tb_bcd2bin;

  localparam int DIGITS = 11;
  localparam int BIN_W  = 37;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [BIN_W-1:0] model_bin;

  bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record the expected outcome of a request accepted at the next rising edge.
  task automatic push_exp(input logic [4*DIGITS-1:0] v);
    exp_t e;
    logic [63:0] val;
    logic bad;
    val = 64'd0;
    bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      val = val * 64'd10 + 64'(v[4*i +: 4]);
    end
    if (!bad) model_bin = val[BIN_W-1:0];
    e.bin = model_bin;
    e.err = bad;
    e.cyc = cyc + (bad ? 1 : 38);
    sb.push_back(e);
  endtask

  // Hold start with value v until n_acc requests are accepted.
  task automatic issue(input logic [4*DIGITS-1:0] v, input int n_acc);
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    @(negedge clk);
    bus.bcd   = v;
    bus.start = 1'b1;
    while (acc < n_acc && guard < 200) begin
      if (bus.ready) begin
        push_exp(v);
        acc++;
      end
      guard++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (acc < n_acc) check("accept_timeout", 64'(acc), 64'(n_acc));
  endtask

  // Wait until every queued result has been seen and the block is idle.
  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || !bus.ready) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: every done_tick must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.done_tick) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bin", 64'(bus.bin), 64'(e.bin));
        check("err", 64'(bus.err), 64'(e.err));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        if (!e.err) check("digits_consumed", 64'(dut.dig_q), 64'd0);
      end
    end
  end

  initial begin
    logic rdy_seen;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    model_bin = {BIN_W{1'b0}};
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.bcd   = 44'h0;

    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done_tick), 64'd0);
    check("rst_bin", 64'(bus.bin), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All-zero input runs the full iteration count.
    issue(44'h00000000000, 1);
    check("busy_after_accept", 64'(bus.ready), 64'd0);
    drain(100);
    check("ready_after_done", 64'(bus.ready), 64'd1);

    issue(44'h99999999999, 1);
    drain(100);

    issue(44'h00000001234, 1);
    drain(100);
    repeat (10) @(negedge clk);
    check("bin_hold", 64'(bus.bin), 64'h4D2);

    // Invalid digit: immediate done, err set, bin kept.
    issue(44'h0000000A000, 1);
    drain(20);
    check("err_bin_kept", 64'(bus.bin), 64'h4D2);

    issue(44'h00000000042, 1);
    drain(100);
    check("err_cleared", 64'(bus.err), 64'd0);

    // Second start during OP is ignored.
    issue(44'h00000000500, 1);
    rdy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 9) begin
        bus.start = 1'b1;
        bus.bcd   = 44'h00000000777;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("ready_low_in_op", 64'(rdy_seen), 64'd0);
    drain(100);
    check("ignored_restart_bin", 64'(bus.bin), 64'h1F4);

    // Back-to-back: start held through two conversions, 39 cycles apart.
    issue(44'h00000000123, 2);
    drain(100);

    // Reset in the middle of OP aborts without a done_tick.
    issue(44'h00000065535, 1);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_bin", 64'(bus.bin), 64'd0);
    check("abort_err", 64'(bus.err), 64'd0);
    check("abort_done", 64'(bus.done_tick), 64'd0);
    sb.delete();
    model_bin = {BIN_W{1'b0}};
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check("abort_bin_held", 64'(bus.bin), 64'd0);
    issue(44'h00000065535, 1);
    drain(100);
    check("reissue_bin", 64'(bus.bin), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
